// File: rtl/seq_mult16_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package seq_mult16_pkg;

  // Default operand width. The product is twice this width.
  localparam int WIDTH_DEF = 16;

  // Iteration counter width for the default operand width.
  localparam int CNT_W = $clog2(WIDTH_DEF) + 1;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_mult16_if.sv
// Request/result bundle for seq_mult16.
//
// Handshake: the master raises start together with stable operands.
// The slave accepts start only on an edge where it is idle, which means
// busy=0 and done=0. Starts seen while busy or done are dropped and are
// not queued. Operands are captured on the accepting edge only. done is
// a one-cycle pulse. prod is valid while done is high and holds its value
// until the next completion or reset. dbg_state mirrors the controller
// state so that checkers can observe it.
interface seq_mult16_if
  import seq_mult16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic               start;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] prod;
  state_e             dbg_state;

  modport master (
    output start, mcand, mplier,
    input  busy, done, prod, dbg_state
  );

  modport slave (
    input  start, mcand, mplier,
    output busy, done, prod, dbg_state
  );

endinterface

// File: rtl/seq_mult16_dp.sv
// Datapath for the shift-and-add multiplier. It holds the C/A/Q/B
// registers, the WIDTH+1-bit adder and the right shift.
module seq_mult16_dp
  import seq_mult16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             re,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic [WIDTH-1:0] a_next_o,
  output logic [WIDTH-1:0] q_next_o
);

  logic             c_q, c_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   sum;

  // Conditional add of B into {C,A}, steered by the low bit of Q.
  always_comb begin
    addend = q_q[0] ? {1'b0, b_q} : '0;
    sum    = {c_q, a_q} + addend;
  end

  // Select the next register values: load operands, or perform one
  // add-and-shift step. Shifting {0,sum,Q} right by one bit moves the
  // carry into the top of A and moves sum[0] into the top of Q. C
  // always shifts in as zero.
  always_comb begin
    c_d = c_q;
    a_d = a_q;
    q_d = q_q;
    b_d = b_q;
    if (load_i) begin
      c_d = 1'b0;
      a_d = '0;
      q_d = mplier_i;
      b_d = mcand_i;
    end else if (step_i) begin
      c_d = 1'b0;
      a_d = sum[WIDTH:1];
      q_d = {sum[0], q_q[WIDTH-1:1]};
    end
  end

  // The post-shift values let the controller capture the product on the
  // same edge that performs the final iteration.
  assign a_next_o = a_d;
  assign q_next_o = q_d;

  // Register update. Reset clears all working registers.
  always_ff @(posedge clk) begin
    if (re) begin
      c_q <= 1'b0;
      a_q <= '0;
      q_q <= '0;
      b_q <= '0;
    end else begin
      c_q <= c_d;
      a_q <= a_d;
      q_q <= q_d;
      b_q <= b_d;
    end
  end

endmodule

// File: rtl/seq_mult16.sv
// Sequential unsigned multiplier. This module holds the controller, the
// iteration counter and the product register. The arithmetic is in
// seq_mult16_dp. A result appears WIDTH cycles after start is accepted.
module seq_mult16
  import seq_mult16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic        clk,
  input  logic        re,
  seq_mult16_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               load;
  logic               step;
  logic [WIDTH-1:0]   a_next;
  logic [WIDTH-1:0]   q_next;

  seq_mult16_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk      (clk),
    .re       (re),
    .load_i   (load),
    .step_i   (step),
    .mcand_i  (bus.mcand),
    .mplier_i (bus.mplier),
    .a_next_o (a_next),
    .q_next_o (q_next)
  );

  // Next-state logic, counter, product capture and datapath control.
  // Start is honoured only in IDLE. DONE always lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          prod_d  = {a_next, q_next};
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter and product registers. Reset has priority over start.
  always_ff @(posedge clk) begin
    if (re) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.prod      = prod_q;
  assign bus.dbg_state = state_q;

endmodule
